// File: rtl/distance_pkg.sv
// distance_pkg -- shared definitions for the distance moving-average filter.
//   DIST_W                  : width of one distance sample
//   MAX_DIST_DEFAULT        : largest sample value accepted into the window
//   TIMEOUT_CYCLES_DEFAULT  : idle cycles without an accepted sample before a flush
//   filt_state_t            : FILL (window not yet full) / RUN (window full)
package distance_pkg;

  localparam int DIST_W = 32;

  localparam logic [DIST_W-1:0] MAX_DIST_DEFAULT       = 32'd23200;
  localparam logic [31:0]       TIMEOUT_CYCLES_DEFAULT = 32'd10_000_000;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } filt_state_t;

endpackage

// File: rtl/distance_sample_buf.sv
// distance_sample_buf -- window storage for the distance filter.
// A DEPTH x DIST_W register array with one write port and a combinational
// read of the slot addressed by wr_ptr (the slot about to be overwritten,
// i.e. the oldest sample once the window is full).
//   clk     : clock, rising edge
//   clr     : synchronous clear of every slot (reset or timeout flush)
//   we      : write enable for wr_data into slot wr_ptr
//   wr_ptr  : write address, also the read address
//   wr_data : sample to store
//   rd_data : current content of slot wr_ptr
module distance_sample_buf
  import distance_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DIST_W-1:0] wr_data,
  output logic [DIST_W-1:0] rd_data
);

  logic [DIST_W-1:0] slots [DEPTH];

  // NOTE: this array is cleared on purpose: the running sum assumes every
  // slot it has not yet written holds zero, so stale contents must not
  // survive a reset or flush. Plain data memories normally skip this.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (we) begin
      slots[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = slots[wr_ptr];

endmodule

// File: rtl/distance_filter.sv
// distance_filter -- moving-average filter between the ultrasonic sensor
// controller and the PWM controller.
// Samples above MAX_DIST are dropped (REJECT pulse). Accepted samples enter a
// DEPTH-deep circular window; a running sum is kept so each new average costs
// one add and one subtract. Once the window is full, every accepted sample
// produces a new average one cycle later. If no sample is accepted for
// TIMEOUT_CYCLES cycles the window is flushed and STALE is raised until the
// next average is published.
//   clk            : clock, rising edge
//   rst            : synchronous, active-high reset
//   DISTANCE       : raw 32-bit sample
//   DISTANCE_VALID : one sample per cycle while high
//   FILT_DISTANCE  : registered window average, held between updates
//   FILT_VALID     : one-cycle pulse marking a new FILT_DISTANCE
//   REJECT         : one-cycle pulse marking a discarded out-of-range sample
//   STALE          : level, window flushed by timeout and not yet refilled
module distance_filter
  import distance_pkg::*;
#(
  parameter int                DEPTH          = 8,
  parameter logic [DIST_W-1:0] MAX_DIST       = MAX_DIST_DEFAULT,
  parameter logic [31:0]       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIST_W-1:0] DISTANCE,
  input  logic              DISTANCE_VALID,
  output logic [DIST_W-1:0] FILT_DISTANCE,
  output logic              FILT_VALID,
  output logic              REJECT,
  output logic              STALE
);

  localparam int SHIFT = $clog2(DEPTH);
  localparam int SUM_W = DIST_W + SHIFT;  // DEPTH full-scale samples never overflow
  localparam int CNT_W = SHIFT + 1;       // must be able to hold DEPTH itself

  filt_state_t       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SHIFT-1:0]  wr_ptr_q;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [31:0]       tmo_q;
  logic              accept, reject, flush, emit;
  logic [DIST_W-1:0] old_slot, evicted;

  assign accept = DISTANCE_VALID && (DISTANCE <= MAX_DIST);
  assign reject = DISTANCE_VALID && (DISTANCE > MAX_DIST);
  // An accepted sample in the terminal cycle wins over the flush.
  assign flush  = (tmo_q == TIMEOUT_CYCLES - 32'd1) && !accept;

  // Slots are all zero while filling, so gating is belt-and-braces only.
  assign evicted = (state_q == RUN) ? old_slot : '0;
  assign sum_d   = sum_q + SUM_W'(DISTANCE) - SUM_W'(evicted);

  distance_sample_buf #(
    .DEPTH (DEPTH),
    .PTR_W (SHIFT)
  ) u_buf (
    .clk     (clk),
    .clr     (rst || flush),
    .we      (accept),
    .wr_ptr  (wr_ptr_q),
    .wr_data (DISTANCE),
    .rd_data (old_slot)
  );

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    emit    = 1'b0;
    if (flush) begin
      state_d = FILL;
      count_d = '0;
    end else if (accept) begin
      if (state_q == RUN) begin
        emit = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(DEPTH - 1)) begin
          state_d = RUN;
          emit    = 1'b1;
        end
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      sum_q         <= '0;
      tmo_q         <= '0;
      FILT_DISTANCE <= '0;
      FILT_VALID    <= 1'b0;
      REJECT        <= 1'b0;
      STALE         <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      FILT_VALID <= emit;
      REJECT     <= reject;
      if (flush) begin
        wr_ptr_q <= '0;
        sum_q    <= '0;
        tmo_q    <= '0;
        STALE    <= 1'b1;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + SHIFT'(1);
        sum_q    <= sum_d;
        tmo_q    <= '0;
      end else begin
        tmo_q <= tmo_q + 32'd1;
      end
      // FILT_DISTANCE deliberately survives a flush; only a new average moves it.
      if (emit) begin
        FILT_DISTANCE <= sum_d[SUM_W-1:SHIFT];
        STALE         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_distance_filter.sv
// tb_distance_filter -- scoreboard bench for distance_filter (DEPTH=8,
// MAX_DIST=23200, TIMEOUT_CYCLES=50). Stimulus pushes the hand-computed
// average and the cycle it must appear in; a negedge monitor pops and
// compares whenever FILT_VALID or REJECT is high.
module tb_distance_filter;
  import distance_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] DISTANCE = '0;
  logic        DISTANCE_VALID = 1'b0;
  logic [31:0] FILT_DISTANCE;
  logic        FILT_VALID, REJECT, STALE;

  distance_filter #(
    .DEPTH          (8),
    .MAX_DIST       (32'd23200),
    .TIMEOUT_CYCLES (32'd50)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .DISTANCE       (DISTANCE),
    .DISTANCE_VALID (DISTANCE_VALID),
    .FILT_DISTANCE  (FILT_DISTANCE),
    .FILT_VALID     (FILT_VALID),
    .REJECT         (REJECT),
    .STALE          (STALE)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
  } exp_t;

  exp_t        filt_q[$];
  int unsigned rej_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Present one sample on the next edge; optionally predict its outputs.
  task automatic send(input logic [31:0] d, input bit pulse, input logic [31:0] avg,
                      input bit rej);
    exp_t e;
    @(negedge clk);
    DISTANCE       = d;
    DISTANCE_VALID = 1'b1;
    e.cyc = cyc + 1;
    e.val = avg;
    if (pulse) filt_q.push_back(e);
    if (rej) rej_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    DISTANCE_VALID = 1'b0;
  endtask

  task automatic send_n(input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) send(d, 1'b0, '0, 1'b0);
  endtask

  // Monitor: every output event must match the front of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (FILT_VALID === 1'b1) begin
      if (filt_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL filt_valid: unexpected pulse at cycle %0d value %0d, expected none",
                 cyc, FILT_DISTANCE);
      end else begin
        e = filt_q.pop_front();
        check("filt_cycle", 64'(cyc), 64'(e.cyc));
        check("filt_distance", 64'(FILT_DISTANCE), 64'(e.val));
      end
    end
    if (REJECT === 1'b1) begin
      if (rej_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL reject: unexpected pulse at cycle %0d, expected none", cyc);
      end else begin
        check("reject_cycle", 64'(cyc), 64'(rej_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_filt_distance", 64'(FILT_DISTANCE), 64'd0);
    check("rst_filt_valid", 64'(FILT_VALID), 64'd0);
    check("rst_reject", 64'(REJECT), 64'd0);
    check("rst_stale", 64'(STALE), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(FILL));

    // Fill with 100: single pulse one cycle after the 8th sample
    send_n(7, 32'd100);
    send(32'd100, 1'b1, 32'd100, 1'b0);

    // 180 replaces a 100: 880/8 = 110
    send(32'd180, 1'b1, 32'd110, 1'b0);

    // Out of range: reject, no pulse, average held
    send(32'd30000, 1'b0, '0, 1'b1);
    check("reject_hold", 64'(FILT_DISTANCE), 64'd110);
    // Boundary: MAX_DIST accepted (880-100+23200 = 23980 -> 2997), MAX_DIST+1 rejected
    send(32'd23200, 1'b1, 32'd2997, 1'b0);
    send(32'd23201, 1'b0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("boundary_hold", 64'(FILT_DISTANCE), 64'd2997);

    // Timeout: 100 replaces a 100 (avg stays 2997), then 50 idle cycles
    send(32'd100, 1'b1, 32'd2997, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    check("pre_timeout_stale", 64'(STALE), 64'd0);
    check("pre_timeout_state", 64'(dut.state_q), 64'(RUN));
    @(posedge clk);
    #1;
    check("timeout_stale", 64'(STALE), 64'd1);
    check("timeout_state", 64'(dut.state_q), 64'(FILL));
    check("timeout_hold", 64'(FILT_DISTANCE), 64'd2997);

    // Refill after flush: 8 new samples needed, STALE clears with the pulse
    send_n(7, 32'd200);
    check("refill_stale", 64'(STALE), 64'd1);
    send(32'd200, 1'b1, 32'd200, 1'b0);
    check("refill_stale_clear", 64'(STALE), 64'd0);

    // Accepted sample in the terminal timeout cycle wins: 1600-200+280 = 1680 -> 210
    repeat (49) @(posedge clk);
    send(32'd280, 1'b1, 32'd210, 1'b0);
    check("terminal_stale", 64'(STALE), 64'd0);
    check("terminal_state", 64'(dut.state_q), 64'(RUN));
    repeat (10) @(posedge clk);
    #1 check("terminal_no_flush", 64'(STALE), 64'd0);

    // Back-to-back samples in RUN, each evicting a 200
    send(32'd48, 1'b1, 32'd191, 1'b0);
    send(32'd48, 1'b1, 32'd172, 1'b0);
    send(32'd0, 1'b1, 32'd147, 1'b0);

    // Reset clears outputs, then reset mid-fill with a sample in the reset cycle
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst2_filt_distance", 64'(FILT_DISTANCE), 64'd0);
    check("rst2_stale", 64'(STALE), 64'd0);
    send_n(5, 32'd999);
    @(negedge clk);
    rst            = 1'b1;
    DISTANCE       = 32'd5000;
    DISTANCE_VALID = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    DISTANCE_VALID = 1'b0;
    check("rst3_state", 64'(dut.state_q), 64'(FILL));
    check("rst3_filt_distance", 64'(FILT_DISTANCE), 64'd0);
    send_n(7, 32'd40);
    send(32'd40, 1'b1, 32'd40, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("filt_queue_empty", 64'(filt_q.size()), 64'd0);
    check("reject_queue_empty", 64'(rej_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the moving-average window length; DEPTH SHALL be a power of two, 2 to 64.
REQ-002 The block SHALL have parameter MAX_DIST, default 32'd23200, meaning the largest sample value accepted into the window.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd10_000_000, meaning the number of cycles without an accepted sample before the window is flushed.
REQ-004 clk  input  1  single clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 DISTANCE  input  32  raw sample from the sensor controller.
REQ-007 DISTANCE_VALID  input  1  sample qualifier; each cycle it is high is one sample.
REQ-008 FILT_DISTANCE  output  32  registered window average, fed to the PWM controller's DISTANCE input.
REQ-009 FILT_VALID  output  1  one-cycle pulse marking a new FILT_DISTANCE value.
REQ-010 REJECT  output  1  one-cycle pulse marking a sample discarded as out of range.
REQ-011 STALE  output  1  level; high when the window has been flushed by timeout.

Function
REQ-012 States SHALL be FILL (window not yet full) and RUN (window full).
REQ-013 A sample with DISTANCE_VALID=1 and DISTANCE > MAX_DIST SHALL be discarded, and REQ SHALL pulse REJECT in the next cycle; the window, sum and timeout counter SHALL be unchanged.
REQ-014 A sample with DISTANCE_VALID=1 and DISTANCE <= MAX_DIST is "accepted": it SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-015 On each accepted sample, sum SHALL update to sum + new - evicted; evicted is the slot's old content, which is 0 in FILL.
REQ-016 sum SHALL be 32+log2(DEPTH) bits wide and SHALL never overflow or truncate.
REQ-017 In FILL, count SHALL increment per accepted sample; the sample that makes count equal DEPTH SHALL move the state to RUN.
REQ-018 FILT_VALID SHALL stay 0 in FILL.
REQ-019 FILT_VALID SHALL pulse exactly one cycle after the accepted sample that enters RUN, and one cycle after every accepted sample in RUN.
REQ-020 When FILT_VALID pulses, FILT_DISTANCE SHALL equal the updated sum >> log2(DEPTH), truncating.
REQ-021 FILT_DISTANCE SHALL hold its value between pulses.
REQ-022 The timeout counter SHALL reset to 0 on every accepted sample and increment otherwise; rejected samples SHALL NOT reset it.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES-1 with no accepted sample that cycle, the next cycle SHALL clear all slots, sum, count and wr_ptr, enter FILL and set STALE=1.
REQ-024 On a flush, FILT_DISTANCE SHALL hold its last value.
REQ-025 If an accepted sample arrives in the terminal timeout cycle, the sample SHALL win: no flush, and the counter resets.
REQ-026 STALE SHALL clear in the same cycle FILT_VALID next pulses.
REQ-027 Back-to-back accepted samples on consecutive cycles SHALL each be processed; throughput SHALL be one sample per cycle with no stalls.

Reset
REQ-028 On rst=1 at a clock edge, the state SHALL become FILL.
REQ-029 On reset, count, wr_ptr, sum, timeout counter and all window slots SHALL be 0.
REQ-030 On reset, FILT_DISTANCE, FILT_VALID, REJECT and STALE SHALL be 0.
REQ-031 Reset mid-window SHALL discard all partial history; a sample presented in the reset cycle SHALL be ignored.

Structure
REQ-032 Package distance_pkg SHALL hold DIST_W=32, the state enum type (FILL, RUN) and the default MAX_DIST and TIMEOUT_CYCLES constants.
REQ-033 Window storage SHALL be a sub-module, distance_sample_buf: a DEPTH x 32 register array with synchronous clear, one write port and a combinational read of the slot at wr_ptr.
REQ-034 The filter SHALL be inserted between SensorController and PWMController with no change to either.

Verification
REQ-035 The bench SHALL cover: reset, then 8 samples of 100 -> FILT_VALID pulses once, 1 cycle after the 8th sample, with FILT_DISTANCE=100; no pulse before it.
REQ-036 The bench SHALL cover: a full window of 100, then one sample of 180 -> FILT_DISTANCE=110 (sum 880/8).
REQ-037 The bench SHALL cover: a sample of 30000 in RUN -> REJECT pulses, there is no FILT_VALID, and FILT_DISTANCE is unchanged.
REQ-038 The bench SHALL cover: TIMEOUT_CYCLES=50, a full window, then 50 idle cycles -> STALE=1, FILL state, and 8 more samples are needed before FILT_VALID.
REQ-039 The bench SHALL cover: an accepted sample in the terminal timeout cycle -> no flush and STALE stays 0.
REQ-040 The bench SHALL cover: rst asserted after 5 of 8 samples, then 8 samples of 40 -> the first FILT_DISTANCE is 40.
